reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 35 +++
 rtl/register16.sv | 23 ++
 rtl/reg_file.sv | 61 ++++++
 tb/tb_reg_file.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants for the register file, the ALU and the decode stage.
// Build option REGFILE_BYPASS_EN is consumed by reg_file.sv, not here.
package reg_file_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int R0_IDX     = 0;
  localparam int NUM_REGS   = 2 ** DEF_ADDR_W;

  // Operation select shared between decode and the ALU.
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  function automatic logic [DEF_DATA_W-1:0] alu_eval(
    input alu_op_e               op,
    input logic [DEF_DATA_W-1:0] a,
    input logic [DEF_DATA_W-1:0] b
  );
    logic [DEF_DATA_W-1:0] r;
    r = '0;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/register16.sv
// Single storage register with synchronous active-high clear and load enable.
// Clear wins over load so a write colliding with reset is dropped.
module register16
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file; R0 is hardwired to zero, reads are combinational.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int N = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [N];
  logic [DATA_W-1:0] stored_a;
  logic [DATA_W-1:0] stored_b;

  // R0 has no storage; index 0 of the array is a constant.
  assign regs[R0_IDX] = '0;

  for (genvar i = 1; i < N; i++) begin : g_reg
    register16 #(
      .WIDTH(DATA_W)
    ) u_reg (
      .clk(clk),
      .rst(rst),
      .we (wr_en && (wr_addr == ADDR_W'(i))),
      .d  (wr_data),
      .q  (regs[i])
    );
  end

  assign stored_a = regs[rd_addr_a];
  assign stored_b = regs[rd_addr_b];

`ifdef REGFILE_BYPASS_EN
  logic wr_live;
  logic hit_a;
  logic hit_b;

  // A write only forwards if it would actually land: not during reset, not to R0.
  assign wr_live = wr_en && !rst && (wr_addr != ADDR_W'(R0_IDX));
  assign hit_a   = wr_live && (rd_addr_a == wr_addr);
  assign hit_b   = wr_live && (rd_addr_b == wr_addr);

  assign rd_data_a = hit_a ? wr_data : stored_a;
  assign rd_data_b = hit_b ? wr_data : stored_b;
`else
  assign rd_data_a = stored_a;
  assign rd_data_b = stored_b;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed plus random bench for reg_file against an array-based reference model.
module tb_reg_file;

  localparam int DW = 16;
  localparam int AW = 4;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl [16];
  bit            mdl_valid = 1'b0;
  logic [DW-1:0] oa, ob;

  reg_file dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0;
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference read: R0 is zero, a live write forwards in bypass builds, otherwise stored value.
  function automatic logic [DW-1:0] model_read(input logic r, input logic we, input logic [AW-1:0] wa,
                                               input logic [DW-1:0] wd, input logic [AW-1:0] ra);
    if (ra == 0) return '0;
    if (BYP && we && !r && wa != 0 && wa == ra) return wd;
    return mdl[ra];
  endfunction

  // One cycle: drive after negedge, sample reads 1ns later, commit the model at posedge.
  task automatic step(input logic r, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      output logic [DW-1:0] obs_a, output logic [DW-1:0] obs_b);
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
    #1;
    obs_a = rd_data_a;
    obs_b = rd_data_b;
    if (mdl_valid) begin
      check("rd_a_model", obs_a, model_read(r, we, wa, wd, ra));
      check("rd_b_model", obs_b, model_read(r, we, wa, wd, rb));
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 16; i++) mdl[i] = '0;
      mdl_valid = 1'b1;
    end else if (we && wa != 0) begin
      mdl[wa] = wd;
    end
  endtask

  task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    step(1'b0, 1'b1, wa, wd, 4'd0, 4'd0, oa, ob);
  endtask

  task automatic rd(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    step(1'b0, 1'b0, 4'd0, 16'h0, ra, rb, oa, ob);
  endtask

  initial begin
    // Reset, then every address must read zero on both ports.
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, oa, ob);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 4'(15 - i));
      check("post_reset_a", oa, 16'h0000);
      check("post_reset_b", ob, 16'h0000);
    end

    // Reset clear of a written register.
    wr(4'd5, 16'hBEEF);
    rd(4'd5, 4'd0);
    check("r5_written", oa, 16'hBEEF);
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd5, 4'd5, oa, ob);
    rd(4'd5, 4'd5);
    check("r5_after_rst", oa, 16'h0000);

    // R0 discards writes.
    wr(4'd0, 16'h1234);
    rd(4'd0, 4'd0);
    check("r0_write_a", oa, 16'h0000);
    check("r0_write_b", ob, 16'h0000);

    // Dual read, including both ports on one register.
    wr(4'd3, 16'h7FFF);
    wr(4'd4, 16'h8000);
    rd(4'd3, 4'd4);
    check("dual_a", oa, 16'h7FFF);
    check("dual_b", ob, 16'h8000);
    rd(4'd3, 4'd3);
    check("same_a", oa, 16'h7FFF);
    check("same_b", ob, 16'h7FFF);

    // Same-cycle read of the register being written.
    wr(4'd7, 16'h0001);
    step(1'b0, 1'b1, 4'd7, 16'hDEAD, 4'd7, 4'd7, oa, ob);
    check("same_cycle", oa, BYP ? 16'hDEAD : 16'h0001);
    rd(4'd7, 4'd0);
    check("next_cycle", oa, 16'hDEAD);

    // Reset/write collision: reset wins and bypass is suppressed.
    wr(4'd9, 16'h5555);
    step(1'b1, 1'b1, 4'd9, 16'hAAAA, 4'd9, 4'd9, oa, ob);
    check("collision_during", oa, 16'h5555);
    rd(4'd9, 4'd9);
    check("collision_after", oa, 16'h0000);

    // ALU writeback loop: operands read from the file, sum written back.
    wr(4'd1, 16'd10);
    wr(4'd2, 16'd20);
    rd(4'd1, 4'd2);
    step(1'b0, 1'b1, 4'd3, oa + ob, 4'd1, 4'd2, oa, ob);
    rd(4'd3, 4'd0);
    check("alu_add_wb", oa, 16'd30);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)),
           16'($urandom),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           oa, ob);
    end

    // Held state: idle cycles leave contents unchanged.
    for (int i = 0; i < 16; i++) rd(4'(i), 4'(i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
